// File: rtl/pong_lane_if.sv
// Handshake bundle for the single-lane pong game: timebase, buttons, display and score outputs.
// The master side drives tick and the buttons; the slave side is the game core.
interface pong_lane_if #(
    parameter int N_LEDS  = 8,
    parameter int SCORE_W = 4
);
    logic               tick;
    logic               btn_l;
    logic               btn_r;
    logic [N_LEDS-1:0]  leds;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic               point;
    logic               point_side;
    logic               game_over;
    logic               winner;

    modport master (
        output tick, btn_l, btn_r,
        input  leds, score_l, score_r, point, point_side, game_over, winner
    );

    modport slave (
        input  tick, btn_l, btn_r,
        output leds, score_l, score_r, point, point_side, game_over, winner
    );
endinterface

// File: rtl/pong_lane.sv
// One-dimensional pong: a ball walks along an LED lane and players must press exactly
// when it sits on their end LED. The lane speeds up on every return.
//
// state  | meaning
// SERVE  | ball parked at server end, waiting for the server's press
// MOVE_R | ball travelling toward LED N_LEDS-1, right player receives
// MOVE_L | ball travelling toward LED 0, left player receives
// OVER   | game decided, lane fully lit, both buttons together restart
module pong_lane #(
    parameter int N_LEDS    = 8,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 15,
    parameter int DIV_W     = 4,
    parameter int BASE_DIV  = 4,
    parameter int MIN_DIV   = 1
) (
    input  logic       clk,
    input  logic       reset,
    pong_lane_if.slave lane_if
);
    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [POS_W-1:0]   POS_END  = POS_W'(N_LEDS - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [DIV_W-1:0]   DIV_BASE = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0]   DIV_MIN  = DIV_W'(MIN_DIV);

    typedef enum logic [1:0] {SERVE, MOVE_R, MOVE_L, OVER} state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               serve_r_q, serve_r_d;
    logic               winner_q, winner_d;
    logic               point_q, point_d;
    logic               point_side_q, point_side_d;
    logic               btn_l_q, btn_r_q, arm_q;

    logic               press_l, press_r, step_due;
    logic [DIV_W:0]     cnt_inc;
    logic               award, award_r;
    logic [SCORE_W-1:0] scored;

    // arm_q masks the first cycle after reset so a button held through release is not a press
    assign press_l  = lane_if.btn_l & ~btn_l_q & arm_q;
    assign press_r  = lane_if.btn_r & ~btn_r_q & arm_q;
    assign cnt_inc  = {1'b0, cnt_q} + {{DIV_W{1'b0}}, 1'b1};
    assign step_due = lane_if.tick & (cnt_inc >= {1'b0, div_q});

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        serve_r_d    = serve_r_q;
        winner_d     = winner_q;
        point_d      = 1'b0;
        point_side_d = point_side_q;
        award        = 1'b0;
        award_r      = 1'b0;
        scored       = '0;

        case (state_q)
            SERVE: begin
                pos_d = serve_r_q ? POS_END : '0;
                if (serve_r_q ? press_r : press_l) begin
                    state_d = serve_r_q ? MOVE_L : MOVE_R;
                    div_d   = DIV_BASE;
                    cnt_d   = '0;
                end
            end
            MOVE_R: begin
                if (press_r) begin
                    if (pos_q == POS_END) begin
                        state_d = MOVE_L;
                        div_d   = (div_q > DIV_MIN) ? div_q - DIV_W'(1) : DIV_MIN;
                        cnt_d   = '0;
                    end else begin
                        award = 1'b1;
                    end
                end else if (step_due) begin
                    if (pos_q == POS_END) begin
                        award = 1'b1;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                        cnt_d = '0;
                    end
                end else if (lane_if.tick) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            MOVE_L: begin
                if (press_l) begin
                    if (pos_q == '0) begin
                        state_d = MOVE_R;
                        div_d   = (div_q > DIV_MIN) ? div_q - DIV_W'(1) : DIV_MIN;
                        cnt_d   = '0;
                    end else begin
                        award   = 1'b1;
                        award_r = 1'b1;
                    end
                end else if (step_due) begin
                    if (pos_q == '0) begin
                        award   = 1'b1;
                        award_r = 1'b1;
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                        cnt_d = '0;
                    end
                end else if (lane_if.tick) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            OVER: begin
                if (press_l && press_r) begin
                    state_d   = SERVE;
                    score_l_d = '0;
                    score_r_d = '0;
                    serve_r_d = 1'b1;
                    pos_d     = POS_END;
                    cnt_d     = '0;
                end
            end
            default: state_d = SERVE;
        endcase

        // The loser of the point serves next, from their own end
        if (award) begin
            point_d      = 1'b1;
            point_side_d = award_r;
            serve_r_d    = ~award_r;
            pos_d        = award_r ? '0 : POS_END;
            cnt_d        = '0;
            scored       = award_r ? score_r_q : score_l_q;
            if (scored < WIN) begin
                scored = scored + SCORE_W'(1);
            end
            if (award_r) begin
                score_r_d = scored;
            end else begin
                score_l_d = scored;
            end
            if (scored == WIN) begin
                state_d  = OVER;
                winner_d = award_r;
            end else begin
                state_d = SERVE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SERVE;
            pos_q        <= POS_END;
            cnt_q        <= '0;
            div_q        <= DIV_BASE;
            score_l_q    <= '0;
            score_r_q    <= '0;
            serve_r_q    <= 1'b1;
            winner_q     <= 1'b0;
            point_q      <= 1'b0;
            point_side_q <= 1'b0;
            btn_l_q      <= 1'b0;
            btn_r_q      <= 1'b0;
            arm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            serve_r_q    <= serve_r_d;
            winner_q     <= winner_d;
            point_q      <= point_d;
            point_side_q <= point_side_d;
            btn_l_q      <= lane_if.btn_l;
            btn_r_q      <= lane_if.btn_r;
            arm_q        <= 1'b1;
        end
    end

    assign lane_if.leds       = (state_q == OVER) ? '1 : (N_LEDS'(1) << pos_q);
    assign lane_if.score_l    = score_l_q;
    assign lane_if.score_r    = score_r_q;
    assign lane_if.point      = point_q;
    assign lane_if.point_side = point_side_q;
    assign lane_if.game_over  = (state_q == OVER);
    assign lane_if.winner     = winner_q;
endmodule

// File: tb/tb_pong_lane.sv
// Directed bench for pong_lane: 8-LED lane, serve divider 2, floor 1, game to 3, tick every cycle.
// Point pulses are matched against a queue of expected (side, score_l, score_r) records.
module tb_pong_lane;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    typedef struct packed {
        logic       side;
        logic [3:0] sl;
        logic [3:0] sr;
    } pt_t;

    pt_t exp_q[$];
    pt_t mon_exp;
    pt_t mon_obs;

    pong_lane_if #(.N_LEDS(8), .SCORE_W(4)) lane_if ();

    pong_lane #(
        .N_LEDS(8), .SCORE_W(4), .WIN_SCORE(3),
        .DIV_W(4), .BASE_DIV(2), .MIN_DIV(1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .lane_if(lane_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit right);
        if (right) lane_if.btn_r = 1'b1;
        else       lane_if.btn_l = 1'b1;
        step(1);
        lane_if.btn_l = 1'b0;
        lane_if.btn_r = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic pt_t mk(input logic side, input int sl, input int sr);
        pt_t p;
        p.side = side;
        p.sl   = 4'(sl);
        p.sr   = 4'(sr);
        return p;
    endfunction

    // Scoreboard: every point pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && lane_if.point === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL point_unexpected observed=%0h/%0h/%0h expected=none",
                       lane_if.point_side, lane_if.score_l, lane_if.score_r);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                mon_obs = {lane_if.point_side, lane_if.score_l, lane_if.score_r};
                total++;
                assert (mon_obs === mon_exp) else begin
                    bad++;
                    $error("FAIL point_record observed=%0h expected=%0h", mon_obs, mon_exp);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        lane_if.tick  = 1'b1;
        lane_if.btn_l = 1'b0;
        lane_if.btn_r = 1'b0;

        step(2);
        chk("rst_leds", lane_if.leds, 32'h80);
        chk("rst_score_l", lane_if.score_l, 0);
        chk("rst_score_r", lane_if.score_r, 0);
        chk("rst_point", lane_if.point, 0);
        chk("rst_game_over", lane_if.game_over, 0);
        chk("rst_winner", lane_if.winner, 0);
        reset = 1'b0;
        step(2);

        // Right serves, ball walks left one LED every two ticks
        press(1'b1);
        chk("launch_leds", lane_if.leds, 32'h80);
        step(1);
        chk("launch_hold", lane_if.leds, 32'h80);
        step(1);
        chk("first_step", lane_if.leds, 32'h40);
        for (int i = 5; i >= 0; i--) begin
            step(2);
            chk("walk_left", lane_if.leds, 32'd1 << i);
        end

        // Left returns at LED 0, speed becomes one step per tick
        press(1'b0);
        chk("hit_left", lane_if.leds, 32'h01);
        for (int i = 1; i < 8; i++) begin
            step(1);
            chk("walk_right_fast", lane_if.leds, 32'd1 << i);
        end
        // Press coincides with the due step at the right end: a hit
        press(1'b1);
        chk("hit_right_same_cycle", lane_if.leds, 32'h80);
        chk("no_point_on_hit", lane_if.score_l, 0);
        step(1);
        chk("floor_speed", lane_if.leds, 32'h40);

        // Left presses early at LED 3: right scores, left serves
        step(3);
        chk("ball_at_3", lane_if.leds, 32'h08);
        exp_q.push_back(mk(1'b1, 0, 1));
        press(1'b0);
        chk("fault_point", lane_if.point, 1);
        chk("fault_side", lane_if.point_side, 1);
        chk("fault_score_r", lane_if.score_r, 1);
        chk("fault_serve_left", lane_if.leds, 32'h01);
        step(1);
        chk("point_one_cycle", lane_if.point, 0);

        // Receiver press during serve is ignored
        press(1'b1);
        step(2);
        chk("serve_ignore_recv", lane_if.leds, 32'h01);

        press(1'b0);
        chk("serve_left_launch", lane_if.leds, 32'h01);
        step(14);
        chk("reach_right", lane_if.leds, 32'h80);
        press(1'b1);
        chk("hit_right", lane_if.leds, 32'h80);
        step(7);
        chk("fast_to_left", lane_if.leds, 32'h01);
        press(1'b0);
        chk("hit_left_same_cycle", lane_if.leds, 32'h01);
        chk("hit_left_no_point", lane_if.score_r, 1);
        step(1);
        chk("after_left_hit", lane_if.leds, 32'h02);

        // Right misses: left scores, right serves
        step(6);
        chk("at_right_end", lane_if.leds, 32'h80);
        exp_q.push_back(mk(1'b0, 1, 1));
        step(1);
        chk("miss_score_l", lane_if.score_l, 1);
        chk("miss_serve_right", lane_if.leds, 32'h80);

        // Left misses at LED 0
        press(1'b1);
        chk("serve_right_launch", lane_if.leds, 32'h80);
        step(14);
        chk("reach_left", lane_if.leds, 32'h01);
        step(1);
        chk("left_pending", lane_if.score_r, 1);
        exp_q.push_back(mk(1'b1, 1, 2));
        step(1);
        chk("miss_score_r", lane_if.score_r, 2);
        chk("miss_serve_left", lane_if.leds, 32'h01);

        // Sender press ignored in flight, then right faults early
        press(1'b0);
        step(1);
        press(1'b0);
        chk("sender_press_ignored", lane_if.leds, 32'h02);
        exp_q.push_back(mk(1'b0, 2, 2));
        press(1'b1);
        chk("early_r_score_l", lane_if.score_l, 2);
        chk("early_r_serve", lane_if.leds, 32'h80);
        step(1);
        press(1'b1);
        step(1);
        exp_q.push_back(mk(1'b1, 2, 3));
        press(1'b0);
        chk("over_game_over", lane_if.game_over, 1);
        chk("over_winner", lane_if.winner, 1);
        chk("over_leds", lane_if.leds, 32'hFF);
        chk("over_score_r", lane_if.score_r, 3);

        // OVER: single presses ignored, both together restart
        step(1);
        press(1'b0);
        chk("over_single_l", lane_if.game_over, 1);
        chk("over_frozen_l", lane_if.score_l, 2);
        step(1);
        press(1'b1);
        chk("over_single_r", lane_if.game_over, 1);
        chk("over_frozen_r", lane_if.score_r, 3);
        step(1);
        lane_if.btn_l = 1'b1;
        lane_if.btn_r = 1'b1;
        step(1);
        lane_if.btn_l = 1'b0;
        lane_if.btn_r = 1'b0;
        chk("restart_score_l", lane_if.score_l, 0);
        chk("restart_score_r", lane_if.score_r, 0);
        chk("restart_game_over", lane_if.game_over, 0);
        chk("restart_leds", lane_if.leds, 32'h80);

        // Score a point, then reset mid-rally with btn_r held
        step(1);
        press(1'b1);
        step(1);
        exp_q.push_back(mk(1'b1, 0, 1));
        press(1'b0);
        chk("pre_reset_score_r", lane_if.score_r, 1);
        step(1);
        press(1'b0);
        step(3);
        lane_if.btn_r = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_leds", lane_if.leds, 32'h80);
        chk("mid_rst_score_r", lane_if.score_r, 0);
        chk("mid_rst_point", lane_if.point, 0);
        chk("mid_rst_game_over", lane_if.game_over, 0);
        chk("mid_rst_winner", lane_if.winner, 0);
        step(2);
        reset = 1'b0;
        step(4);
        chk("held_btn_no_launch", lane_if.leds, 32'h80);
        lane_if.btn_r = 1'b0;
        step(1);
        lane_if.btn_r = 1'b1;
        step(1);
        lane_if.btn_r = 1'b0;
        chk("relaunch_leds", lane_if.leds, 32'h80);
        step(2);
        chk("relaunch_step", lane_if.leds, 32'h40);

        step(1);
        chk("points_all_seen", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pong_lane.md
PONG_LANE -- requirements
Module: pong_lane

Interface
REQ-001 Parameter N_LEDS, default 8, lane length in LEDs; legal range 4..32.
REQ-002 Parameter SCORE_W, default 4, width of each score counter.
REQ-003 Parameter WIN_SCORE, default 15, points that end a game; legal range 1..2^SCORE_W-1.
REQ-004 Parameter DIV_W, default 4, width of the step divider.
REQ-005 Parameter BASE_DIV, default 4, ticks per ball step at serve; legal range 1..2^DIV_W-1.
REQ-006 Parameter MIN_DIV, default 1, fastest ticks per step; legal range 1..BASE_DIV.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 tick  in  1  single-cycle timebase enable from an external prescaler.
REQ-010 btn_l / btn_r  in  1 each  debounced, synchronous player buttons (level); left player owns LED 0, right player owns LED N_LEDS-1.
REQ-011 leds  out  N_LEDS  lane display.
REQ-012 score_l / score_r  out  SCORE_W each  player scores.
REQ-013 point  out  1  one-cycle pulse when a point is awarded; point_side out 1 (0 = left scored, 1 = right scored), valid with point.
REQ-014 game_over  out  1; winner  out  1 (0 = left, 1 = right), valid while game_over.

Function
REQ-015 Each button SHALL be rising-edge detected through one register (press = btn & ~btn_q); all rules below use press, never level.
REQ-016 FSM states SHALL be SERVE, MOVE_R (toward N_LEDS-1), MOVE_L (toward 0), OVER.
REQ-017 Ball position pos SHALL be a register in 0..N_LEDS-1; leds SHALL be one-hot at pos in SERVE/MOVE_R/MOVE_L and all ones in OVER.
REQ-018 SERVE: pos held at server end (0 if serve_side=left, N_LEDS-1 if right); only server press matters -> MOVE away from server, divider loaded with BASE_DIV; receiver press ignored.
REQ-019 Step: divider counts ticks; when count reaches cur_div, pos moves one LED in direction of travel and count clears; no movement without tick.
REQ-020 MOVE_R, receiver = right: press_r with pos==N_LEDS-1 -> hit: MOVE_L, cur_div = max(cur_div-1, MIN_DIV), count cleared.
REQ-021 MOVE_R: press_r with pos<N_LEDS-1 -> early-hit fault, left scores.
REQ-022 MOVE_R: step due with pos==N_LEDS-1 and no press_r -> miss, left scores.
REQ-023 MOVE_R: press_l ignored. MOVE_L mirrors REQ-020..023 with sides swapped and end LED 0.
REQ-024 Same-cycle press and step at the receiver end SHALL count as a hit; same-cycle press and step elsewhere SHALL count as a fault.
REQ-025 Point: scorer's counter +1 and point pulses in the same cycle as the transition; loser becomes serve_side; next state SERVE, or OVER if new score == WIN_SCORE (winner = scorer).
REQ-026 Scores SHALL never exceed WIN_SCORE; no arithmetic wrap.
REQ-027 OVER: scores, winner frozen; press_l and press_r in the same cycle -> scores 0, game_over 0, serve_side right, SERVE; any single press ignored.
REQ-028 game_over SHALL be 1 exactly while in OVER.

Reset
REQ-029 Reset SHALL force, at any time including mid-rally: state SERVE, serve_side right, pos N_LEDS-1, leds one-hot bit N_LEDS-1, scores 0, point 0, game_over 0, winner 0, divider count 0, cur_div BASE_DIV, button edge registers 0.
REQ-030 A button held through reset release SHALL NOT register as a press.

Verification (N_LEDS=8, BASE_DIV=2, MIN_DIV=1, WIN_SCORE=3, tick every cycle)
REQ-031 Reset, press_r -> leds 0x80, then 0x40 two ticks later, one step per 2 ticks down to 0x01.
REQ-032 Ball at LED 0, press_l -> MOVE_R, steps every 1 tick; press_r at 0x80 -> MOVE_L, cur_div stays 1 (floor).
REQ-033 Ball at 0x08 in MOVE_L, press_l -> point pulse, point_side=1, score_r=1, serve_side left, leds 0x01.
REQ-034 Ball at 0x01, no press, step due -> score_r +1; press and step same cycle at 0x01 -> hit, no point.
REQ-035 Right reaches 3 -> game_over=1, winner=1, leds 0xFF; single presses ignored; both pressed same cycle -> scores 0, leds 0x80.
REQ-036 Reset asserted mid-rally with btn_r held -> REQ-029 values; no launch until btn_r released and pressed again.
